// File: rtl/k005297_pkg.sv
// Shared types and constants for the K005297 bubble function timer and other ROT20 consumers.
// Function codes, FSM states and the per-function start slot table.
package k005297_pkg;

   typedef enum logic [1:0] {
      FuncRepl = 2'd0,
      FuncSwap = 2'd1,
      FuncGen  = 2'd2,
      FuncAnni = 2'd3
   } func_e;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StPulse = 2'd2
   } state_e;

   localparam int unsigned RingLen  = 20;
   localparam logic [4:0]  LastSlot = 5'd19;

   // ROT20 slot in which each bubble function pulse must begin.
   function automatic logic [4:0] start_slot(func_e f);
      logic [4:0] s;
      case (f)
         FuncRepl: s = 5'd3;
         FuncSwap: s = 5'd8;
         FuncGen:  s = 5'd12;
         default:  s = 5'd16;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/k005297_rot20_decode.sv
// Decodes the one-hot-low ROT20 ring into a slot index plus a valid flag.
// Any pattern other than exactly one low bit reports valid=0 and slot=0.
module k005297_rot20_decode
   import k005297_pkg::*;
(
   input  logic [19:0] rot20_n,
   output logic [4:0]  slot,
   output logic        valid
);

   always_comb begin
      slot  = 5'd0;
      valid = 1'b0;
      for (int k = 0; k < RingLen; k++) begin
         if (rot20_n == ~(20'd1 << k)) begin
            slot  = 5'(k);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/k005297_bubble_func_timer.sv
// Bubble loop position counter and function pulse timer driven by the supervisor's
// subclock enable and ROT20 ring; fires one function pulse per accepted command.
module k005297_bubble_func_timer
   import k005297_pkg::*;
#(
   parameter int unsigned LOOP_LEN  = 584,
   parameter int unsigned POS_W     = 10,
   parameter int unsigned PULSE_LEN = 4
) (
   input  logic             i_MCLK,
   input  logic             i_MRST,
   input  logic             i_CLK2M_PCEN_n,
   input  logic [19:0]      i_ROT20_n,
   input  logic             i_SYS_RST_n,
   input  logic             i_SYS_RUN_FLAG,
   input  logic             i_CMD_VALID,
   input  logic [1:0]       i_CMD_FUNC,
   input  logic [POS_W-1:0] i_CMD_POS,
   output logic             o_CMD_READY,
   output logic [3:0]       o_FUNC_n,
   output logic [POS_W-1:0] o_POS,
   output logic             o_DONE,
   output logic             o_ABORT,
   output logic             o_CMD_ERR,
   output logic             o_ROT_ERR
);

   localparam logic [POS_W-1:0] PosLast = POS_W'(LOOP_LEN - 1);
   localparam logic [4:0]       CntLoad = 5'(PULSE_LEN - 1);

   logic [4:0] slot;
   logic       slot_ok;
   logic       tick;
   logic       good_tick;
   logic       advance;

   state_e           state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [POS_W-1:0] target_q, target_d;
   func_e            func_q, func_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [3:0]       func_n_q, func_n_d;
   logic             done_q, done_d;
   logic             abort_q, abort_d;
   logic             cmd_err_q, cmd_err_d;
   logic             rot_err_q, rot_err_d;

   k005297_rot20_decode u_decode (
      .rot20_n (i_ROT20_n),
      .slot    (slot),
      .valid   (slot_ok)
   );

   assign tick      = ~i_CLK2M_PCEN_n;
   assign good_tick = tick & slot_ok;
   assign advance   = good_tick & i_SYS_RUN_FLAG & (slot == LastSlot);

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      target_d  = target_q;
      func_d    = func_q;
      cnt_d     = cnt_q;
      func_n_d  = func_n_q;
      done_d    = 1'b0;
      abort_d   = 1'b0;
      cmd_err_d = 1'b0;
      rot_err_d = rot_err_q;

      if (tick && !slot_ok) begin
         rot_err_d = 1'b1;
      end

      if (advance) begin
         pos_d = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (i_CMD_VALID) begin
               if (32'(i_CMD_POS) >= LOOP_LEN) begin
                  cmd_err_d = 1'b1;
               end else begin
                  func_d   = func_e'(i_CMD_FUNC);
                  target_d = i_CMD_POS;
                  state_d  = StArmed;
               end
            end
         end
         StArmed: begin
            // Compare against the position before this tick's increment.
            if (good_tick && i_SYS_RUN_FLAG && pos_q == target_q &&
                slot == start_slot(func_q)) begin
               func_n_d = ~(4'b0001 << func_q);
               cnt_d    = CntLoad;
               state_d  = StPulse;
            end
         end
         StPulse: begin
            if (tick) begin
               if (cnt_q == 5'd0) begin
                  func_n_d = 4'hF;
                  done_d   = 1'b1;
                  state_d  = StIdle;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
         end
         default: begin
            state_d  = StIdle;
            func_n_d = 4'hF;
         end
      endcase

      // Supervisor reset overrides everything decided above, including a final tick.
      if (!i_SYS_RST_n) begin
         abort_d   = (state_q == StArmed) || (state_q == StPulse);
         state_d   = StIdle;
         pos_d     = '0;
         cnt_d     = 5'd0;
         func_n_d  = 4'hF;
         done_d    = 1'b0;
         cmd_err_d = 1'b0;
         rot_err_d = 1'b0;
      end
   end

   always_ff @(posedge i_MCLK or posedge i_MRST) begin
      if (i_MRST) begin
         state_q   <= StIdle;
         pos_q     <= '0;
         target_q  <= '0;
         func_q    <= FuncRepl;
         cnt_q     <= 5'd0;
         func_n_q  <= 4'hF;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
         cmd_err_q <= 1'b0;
         rot_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         target_q  <= target_d;
         func_q    <= func_d;
         cnt_q     <= cnt_d;
         func_n_q  <= func_n_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
         cmd_err_q <= cmd_err_d;
         rot_err_q <= rot_err_d;
      end
   end

   assign o_CMD_READY = (state_q == StIdle);
   assign o_FUNC_n    = func_n_q;
   assign o_POS       = pos_q;
   assign o_DONE      = done_q;
   assign o_ABORT     = abort_q;
   assign o_CMD_ERR   = cmd_err_q;
   assign o_ROT_ERR   = rot_err_q;

endmodule

// File: tb/tb_k005297_bubble_func_timer.sv
// Bench for k005297_bubble_func_timer: two instances (pulse length 4 and 6) share stimulus
// and are compared against a transaction-level model of positions, commands and pulses.
module tb_k005297_bubble_func_timer;

   localparam int LOOP = 584;

   logic        clk;
   logic        rst;
   logic        pcen_n;
   logic [19:0] rot;
   logic        sys_rst_n;
   logic        run;
   logic        cmd_valid;
   logic [1:0]  cmd_func;
   logic [9:0]  cmd_pos;

   logic [1:0]  ready, done, abort, cmd_err, rot_err;
   logic [3:0]  func_n [2];
   logic [9:0]  pos [2];

   int vectors;
   int miscompares;

   // Reference model state.
   int m_pos;
   bit m_rot_err;
   bit m_armed [2];
   int m_left  [2];
   int m_func  [2];
   int m_tgt   [2];
   bit m_done  [2];
   bit m_abort [2];
   bit m_err   [2];
   int start_tbl [4] = '{3, 8, 12, 16};

   int          cur_slot;
   int          tick_pct;
   bit          bad_ring_en;
   logic [19:0] bad_ring;

   k005297_bubble_func_timer #(.LOOP_LEN(584), .POS_W(10), .PULSE_LEN(4)) dut0 (
      .i_MCLK(clk), .i_MRST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_ROT20_n(rot),
      .i_SYS_RST_n(sys_rst_n), .i_SYS_RUN_FLAG(run), .i_CMD_VALID(cmd_valid),
      .i_CMD_FUNC(cmd_func), .i_CMD_POS(cmd_pos), .o_CMD_READY(ready[0]),
      .o_FUNC_n(func_n[0]), .o_POS(pos[0]), .o_DONE(done[0]), .o_ABORT(abort[0]),
      .o_CMD_ERR(cmd_err[0]), .o_ROT_ERR(rot_err[0])
   );

   k005297_bubble_func_timer #(.LOOP_LEN(584), .POS_W(10), .PULSE_LEN(6)) dut1 (
      .i_MCLK(clk), .i_MRST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_ROT20_n(rot),
      .i_SYS_RST_n(sys_rst_n), .i_SYS_RUN_FLAG(run), .i_CMD_VALID(cmd_valid),
      .i_CMD_FUNC(cmd_func), .i_CMD_POS(cmd_pos), .o_CMD_READY(ready[1]),
      .o_FUNC_n(func_n[1]), .o_POS(pos[1]), .o_DONE(done[1]), .o_ABORT(abort[1]),
      .o_CMD_ERR(cmd_err[1]), .o_ROT_ERR(rot_err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int plen(int i);
      return (i == 0) ? 4 : 6;
   endfunction

   function automatic logic [3:0] exp_fn(int i);
      if (m_left[i] > 0) return ~(4'b0001 << m_func[i]);
      return 4'hF;
   endfunction

   function automatic logic exp_ready(int i);
      return !m_armed[i] && (m_left[i] == 0);
   endfunction

   task automatic model_reset();
      m_pos = 0;
      m_rot_err = 0;
      for (int i = 0; i < 2; i++) begin
         m_armed[i] = 0; m_left[i] = 0; m_func[i] = 0; m_tgt[i] = 0;
         m_done[i] = 0; m_abort[i] = 0; m_err[i] = 0;
      end
   endtask

   // Drive ring/tick for one MCLK, advance the model, return #1 after the edge.
   task automatic cycle();
      int zeros;
      int sl;
      bit tk;
      bit ok;
      pcen_n = ($urandom_range(0, 99) >= tick_pct);
      rot = bad_ring_en ? bad_ring : ~(20'd1 << cur_slot);
      zeros = 0;
      sl = -1;
      for (int k = 0; k < 20; k++) begin
         if (!rot[k]) begin zeros++; sl = k; end
      end
      ok = (zeros == 1);
      tk = !pcen_n;
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 0; m_abort[i] = 0; m_err[i] = 0;
      end
      if (!sys_rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_abort[i] = m_armed[i] || (m_left[i] > 0);
            m_armed[i] = 0;
            m_left[i] = 0;
         end
         m_pos = 0;
         m_rot_err = 0;
      end else begin
         if (tk && !ok) m_rot_err = 1;
         for (int i = 0; i < 2; i++) begin
            if (m_left[i] > 0) begin
               if (tk) begin
                  m_left[i]--;
                  if (m_left[i] == 0) m_done[i] = 1;
               end
            end else if (m_armed[i]) begin
               if (tk && ok && run && m_pos == m_tgt[i] && sl == start_tbl[m_func[i]]) begin
                  m_armed[i] = 0;
                  m_left[i] = plen(i);
               end
            end else if (cmd_valid) begin
               if (int'(cmd_pos) >= LOOP) m_err[i] = 1;
               else begin
                  m_armed[i] = 1;
                  m_func[i] = int'(cmd_func);
                  m_tgt[i] = int'(cmd_pos);
               end
            end
         end
         if (tk && ok && run && sl == 19) m_pos = (m_pos + 1) % LOOP;
      end
      if (tk && !bad_ring_en) cur_slot = (cur_slot + 1) % 20;
      @(posedge clk);
      #1;
   endtask

   task automatic sys_reset();
      sys_rst_n = 1'b0;
      cycle();
      sys_rst_n = 1'b1;
      cur_slot = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (func_n[i] !== 4'hF || pos[i] !== 10'd0 || done[i] !== 1'b0 || abort[i] !== 1'b0 ||
             cmd_err[i] !== 1'b0 || rot_err[i] !== 1'b0 || ready[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset dut%0d: got fn=%h pos=%0d d=%b a=%b e=%b r=%b rdy=%b want F 0 0 0 0 0 1",
                     i, func_n[i], pos[i], done[i], abort[i], cmd_err[i], rot_err[i], ready[i]);
         end
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_pos_wrap();
      tick_pct = 100; run = 1'b1; cmd_valid = 1'b0;
      sys_reset();
      for (int n = 1; n <= LOOP * 20; n++) begin
         cycle();
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (pos[i] !== 10'(m_pos)) begin
               miscompares++;
               $display("FAIL wrap_pos dut%0d tick %0d: got %0d want %0d", i, n, pos[i], m_pos);
            end
            if (n == 583 * 20 + 19 || n == LOOP * 20) begin
               vectors++;
               if (pos[i] !== ((n == LOOP * 20) ? 10'd0 : 10'd583)) begin
                  miscompares++;
                  $display("FAIL wrap_edge dut%0d tick %0d: got %0d", i, n, pos[i]);
               end
            end
         end
      end
   endtask

   task automatic test_replicate();
      int low_cnt [2];
      int done_cnt [2];
      tick_pct = 100; run = 1'b1;
      sys_reset();
      cmd_valid = 1'b1; cmd_func = 2'd0; cmd_pos = 10'd5;
      cycle();
      cmd_valid = 1'b0;
      low_cnt = '{0, 0};
      done_cnt = '{0, 0};
      for (int t = 1; t <= 115; t++) begin
         cycle();
         for (int i = 0; i < 2; i++) begin
            if (func_n[i] == 4'hE) low_cnt[i]++;
            if (done[i]) done_cnt[i]++;
            vectors++;
            if (func_n[i] !== exp_fn(i) || done[i] !== m_done[i] || ready[i] !== exp_ready(i)) begin
               miscompares++;
               $display("FAIL repl dut%0d t=%0d: got fn=%h d=%b rdy=%b want fn=%h d=%b rdy=%b",
                        i, t, func_n[i], done[i], ready[i], exp_fn(i), m_done[i], exp_ready(i));
            end
            if (t == 103) begin
               vectors++;
               if (func_n[i] !== 4'hE) begin
                  miscompares++;
                  $display("FAIL repl_start dut%0d: got %h want e", i, func_n[i]);
               end
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (low_cnt[i] != plen(i) || done_cnt[i] != 1 || ready[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL repl_width dut%0d: got width=%0d dones=%0d rdy=%b want %0d 1 1",
                     i, low_cnt[i], done_cnt[i], ready[i], plen(i));
         end
      end
   endtask

   task automatic test_wrap_pulse();
      int low_cnt [2];
      int pos_first;
      int pos_last;
      tick_pct = 100; run = 1'b1;
      sys_reset();
      cmd_valid = 1'b1; cmd_func = 2'd3; cmd_pos = 10'd0;
      cycle();
      cmd_valid = 1'b0;
      low_cnt = '{0, 0};
      pos_first = -1; pos_last = -1;
      for (int t = 1; t <= 30; t++) begin
         cycle();
         for (int i = 0; i < 2; i++) begin
            if (func_n[i] == 4'h7) low_cnt[i]++;
            vectors++;
            if (func_n[i] !== exp_fn(i) || pos[i] !== 10'(m_pos) || done[i] !== m_done[i]) begin
               miscompares++;
               $display("FAIL anni dut%0d t=%0d: got fn=%h pos=%0d d=%b want fn=%h pos=%0d d=%b",
                        i, t, func_n[i], pos[i], done[i], exp_fn(i), m_pos, m_done[i]);
            end
         end
         if (func_n[1] == 4'h7) begin
            if (pos_first < 0) pos_first = int'(pos[1]);
            pos_last = int'(pos[1]);
         end
      end
      vectors++;
      if (low_cnt[0] != 4 || low_cnt[1] != 6 || pos_first != 0 || pos_last != 1) begin
         miscompares++;
         $display("FAIL anni_span: got widths %0d/%0d pos %0d->%0d want 4/6 pos 0->1",
                  low_cnt[0], low_cnt[1], pos_first, pos_last);
      end
   endtask

   task automatic test_errors();
      tick_pct = 100; run = 1'b1;
      cmd_valid = 1'b1; cmd_func = 2'd2; cmd_pos = 10'd600;
      cycle();
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (cmd_err[i] !== 1'b1 || ready[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_err dut%0d: got err=%b rdy=%b want 1 1", i, cmd_err[i], ready[i]);
         end
      end
      cycle();
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (cmd_err[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_err_strobe dut%0d: got %b want 0", i, cmd_err[i]);
         end
      end
      bad_ring_en = 1'b1; bad_ring = 20'hFFFFC;
      cycle();
      bad_ring_en = 1'b0;
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rot_err[i] !== 1'b1) begin
               miscompares++;
               $display("FAIL rot_err_sticky dut%0d n=%0d: got %b want 1", i, n, rot_err[i]);
            end
         end
         cycle();
      end
      sys_reset();
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (rot_err[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL rot_err_clear dut%0d: got %b want 0", i, rot_err[i]);
         end
      end
   endtask

   task automatic test_abort();
      tick_pct = 100; run = 1'b1;
      sys_reset();
      cmd_valid = 1'b1; cmd_func = 2'd1; cmd_pos = 10'd10;
      cycle();
      cmd_valid = 1'b0;
      for (int n = 0; n < 5; n++) cycle();
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (ready[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_armed dut%0d: got rdy=%b want 0", i, ready[i]);
         end
      end
      sys_rst_n = 1'b0;
      cycle();
      sys_rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (abort[i] !== 1'b1 || func_n[i] !== 4'hF || ready[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort dut%0d: got a=%b fn=%h rdy=%b want 1 f 1",
                     i, abort[i], func_n[i], ready[i]);
         end
      end
      cycle();
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (abort[i] !== 1'b0 || ready[i] !== 1'b1 || done[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_after dut%0d: got a=%b rdy=%b d=%b want 0 1 0",
                     i, abort[i], ready[i], done[i]);
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      tick_pct = 100; run = 1'b1;
      sys_reset();
      cmd_valid = 1'b1; cmd_func = 2'd0; cmd_pos = 10'd2;
      cycle();
      cmd_valid = 1'b0;
      for (int t = 1; t <= 44; t++) cycle();
      vectors++;
      if (func_n[0] !== 4'hE || pos[0] !== 10'd2) begin
         miscompares++;
         $display("FAIL mrst_setup: got fn=%h pos=%0d want e 2", func_n[0], pos[0]);
      end
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (func_n[i] !== 4'hF || pos[i] !== 10'd0 || done[i] !== 1'b0 || abort[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL mrst_async dut%0d: got fn=%h pos=%0d d=%b a=%b want f 0 0 0",
                     i, func_n[i], pos[i], done[i], abort[i]);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (done[i] !== 1'b0 || abort[i] !== 1'b0 || ready[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL mrst_hold dut%0d: got d=%b a=%b rdy=%b want 0 0 1",
                     i, done[i], abort[i], ready[i]);
         end
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) tick_pct = $urandom_range(30, 100);
         run = ($urandom_range(0, 9) != 0);
         sys_rst_n = ($urandom_range(0, 199) != 0);
         bad_ring_en = ($urandom_range(0, 149) == 0);
         bad_ring = 20'($urandom);
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_func = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) cmd_pos = 10'($urandom_range(0, 1023));
         else cmd_pos = 10'((m_pos + $urandom_range(0, 1)) % LOOP);
         cycle();
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (func_n[i] !== exp_fn(i) || pos[i] !== 10'(m_pos) || ready[i] !== exp_ready(i) ||
                done[i] !== m_done[i] || abort[i] !== m_abort[i] || cmd_err[i] !== m_err[i] ||
                rot_err[i] !== m_rot_err) begin
               miscompares++;
               $display("FAIL rnd dut%0d c=%0d: got fn=%h pos=%0d rdy=%b d=%b a=%b e=%b r=%b want fn=%h pos=%0d rdy=%b d=%b a=%b e=%b r=%b",
                        i, c, func_n[i], pos[i], ready[i], done[i], abort[i], cmd_err[i],
                        rot_err[i], exp_fn(i), m_pos, exp_ready(i), m_done[i], m_abort[i],
                        m_err[i], m_rot_err);
            end
         end
      end
      sys_rst_n = 1'b1;
      bad_ring_en = 1'b0;
      cmd_valid = 1'b0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      pcen_n = 1'b1;
      rot = 20'hFFFFE;
      sys_rst_n = 1'b1;
      run = 1'b0;
      cmd_valid = 1'b0;
      cmd_func = 2'd0;
      cmd_pos = 10'd0;
      cur_slot = 0;
      tick_pct = 100;
      bad_ring_en = 1'b0;
      bad_ring = 20'hFFFFF;
      model_reset();

      test_reset();
      test_pos_wrap();
      test_replicate();
      test_wrap_pulse();
      test_errors();
      test_abort();
      test_reset_mid_pulse();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/k005297_bubble_func_timer.md
Name: k005297_bubble_func_timer

Overview:
- Consumes the supervisor's outputs: 2 MHz subclock enable, ROT20_n ring and system reset/run flags.
- Counts bubble loop positions (one position per full ROT20 revolution).
- Fires one bubble-function pulse (replicate/swap/generate/annihilate) at a commanded loop position and ROT20 slot.
- Sits between the supervisor and the bubble drive/function output pins. It is the timing source for all page read/write functions.

Parameters:
LOOP_LEN, 584, number of bubble positions per minor loop; position counter wraps at LOOP_LEN-1.
POS_W, 10, width of position counter and command target; must satisfy 2^POS_W >= LOOP_LEN.
PULSE_LEN, 4, function pulse length in subclock ticks (1..19).

Ports:
i_MCLK  in  1  master clock; all state updates on rising edge.
i_MRST  in  1  asynchronous, active-high master reset.
i_CLK2M_PCEN_n  in  1  subclock enable, active low; one "tick" = MCLK edge with this low.
i_ROT20_n  in  20  supervisor 20-slot ring, one-hot active low.
i_SYS_RST_n  in  1  supervisor system reset, active low; synchronous clear.
i_SYS_RUN_FLAG  in  1  supervisor run flag; position counting only when high.
i_CMD_VALID  in  1  command request.
i_CMD_FUNC  in  2  0=replicate, 1=swap, 2=generate, 3=annihilate.
i_CMD_POS  in  POS_W  target loop position.
o_CMD_READY  out  1  high in IDLE only.
o_FUNC_n  out  4  per-function pulse outputs, active low, one-hot-low or all high.
o_POS  out  POS_W  current loop position.
o_DONE  out  1  one-MCLK strobe at pulse end.
o_ABORT  out  1  one-MCLK strobe when an armed/pulsing command is killed.
o_CMD_ERR  out  1  one-MCLK strobe on rejected command.
o_ROT_ERR  out  1  sticky, set when i_ROT20_n is not one-hot-low on a tick.

Behaviour:
- Async reset (i_MRST=1) sets the following: state IDLE, o_POS=0, o_FUNC_n=4'hF, o_DONE/o_ABORT/o_CMD_ERR=0, o_ROT_ERR=0, pulse counter=0.
- Synchronous clear: i_SYS_RST_n=0 on any MCLK edge clears o_POS and o_ROT_ERR and forces IDLE with o_FUNC_n=4'hF. If the state was ARMED or PULSE, it also strobes o_ABORT for one cycle.
- Slot decode: slot k is the index of the single 0 in i_ROT20_n. Any other pattern means no slot. Such a pattern sets o_ROT_ERR on a tick and suppresses both counting and firing on that tick.
- Position counter: advances only on a tick with i_SYS_RUN_FLAG=1 and slot 19. It advances LOOP_LEN-1 -> 0, otherwise +1. With run flag low, the counter holds.
- FSM IDLE: o_CMD_READY=1. On i_CMD_VALID:
  - if i_CMD_POS >= LOOP_LEN, strobe o_CMD_ERR next cycle and stay IDLE;
  - otherwise latch func and pos, then go to ARMED.
  Accept/reject latency is 1 MCLK.
- FSM ARMED: fire on a tick where o_POS == target, slot == START_SLOT[func] and run flag = 1. Firing drives o_FUNC_n[func] low from the next MCLK edge, loads pulse counter = PULSE_LEN-1, and goes to PULSE. The target position compared is the value before any increment on the same tick.
- FSM PULSE: on each tick, if counter == 0, release o_FUNC_n to 4'hF, strobe o_DONE and go to IDLE; otherwise decrement. The pulse may span the slot-19 wrap and a position increment unchanged. Run flag falling during PULSE does not shorten the pulse.
- Commands presented while not IDLE are ignored (ready low); the requester must hold valid.
- A new command is accepted no earlier than the MCLK after o_DONE.
- Simultaneous i_SYS_RST_n=0 with a firing or final tick: reset wins, o_ABORT only, no o_DONE.

Decomposition:
- Package k005297_pkg: func enum (REPL, SWAP, GEN, ANNI), START_SLOT table (REPL=3, SWAP=8, GEN=12, ANNI=16), FSM state enum.
- Sub-module k005297_rot20_decode: one-hot-low to 5-bit slot index plus valid flag. Purely combinational, reused by other consumers of the ring.

Test Plan:
- Reset: assert i_MRST mid-PULSE -> o_FUNC_n=4'hF and o_POS=0 immediately; o_DONE and o_ABORT stay 0.
- Position wrap: LOOP_LEN=584, run flag high, valid ring for 584*20 ticks -> o_POS goes 583 -> 0 exactly on the slot-19 tick.
- Replicate: cmd func=0, pos=5, PULSE_LEN=4 -> o_FUNC_n[0] low starting the MCLK after the tick at pos 5/slot 3, for 4 ticks; o_DONE 1 cycle; ready back high.
- Wrap-spanning pulse: cmd func=3 (slot 16) with PULSE_LEN=6 -> pulse covers slots 16-19 and 0-1; o_POS increments mid-pulse; width still 6 ticks.
- Errors: cmd pos=600 -> o_CMD_ERR strobe, state IDLE. Ring 20'hFFFFC on a tick -> o_ROT_ERR=1 sticky until i_SYS_RST_n=0.
- Abort: cmd func=1 armed, pull i_SYS_RST_n low for 1 MCLK -> o_ABORT strobe, no pulse, o_CMD_READY=1 next cycle.
